// File: rtl/ptr_sync_gray.sv
// ptr_sync_gray: brings a gray-coded pointer from a foreign clock domain into
// wclk through a SYNC_STAGES-deep flop chain, converts it to binary and reports
// the per-cycle modular advance (step) with a one-cycle update strobe.
// A FILL/LOAD priming sequence after reset takes the first synchronised value
// as the baseline, so a nonzero foreign pointer at reset release is not
// reported as an advance.
// Optional step checker: define PTR_SYNC_STEP_CHK_EN to build a sticky
// step_err flag that is set when an advance exceeds MAX_STEP.
module ptr_sync_gray #(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 1
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [PTR_W-1:0] rptr,
    input  logic             err_clr,
    output logic [PTR_W-1:0] wq2_rptr,
    output logic [PTR_W-1:0] wq_rptr_bin,
    output logic [PTR_W-1:0] wq_rptr_step,
    output logic             wq_rptr_upd,
    output logic             step_err
);

    // Elaboration-time guard on the parameter ranges the structure relies on.
    if (PTR_W < 2 || SYNC_STAGES < 2 || MAX_STEP < 0) begin : g_bad_param
        $error("ptr_sync_gray: PTR_W and SYNC_STAGES must be >= 2, MAX_STEP >= 0");
    end

    localparam int               CNT_W    = $clog2(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    logic [PTR_W-1:0]                  bin_d;
    logic [PTR_W-1:0]                  diff_d;
    state_t                            state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [PTR_W-1:0]                  bin_q;
    logic [PTR_W-1:0]                  step_q;
    logic                              upd_q;

    // Synchroniser chain: stage 0 samples the foreign pointer, each later
    // stage copies its predecessor. Only the last stage is used downstream.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
        end
    end

    assign wq2_rptr = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all gray bits from the MSB down to i.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < PTR_W; i++) begin
            bin_d[i] = ^(wq2_rptr >> i);
        end
    end

    // Advance since the last registered binary value; wraps modulo 2^PTR_W.
    assign diff_d = bin_d - bin_q;

    // Priming FSM with registered outputs. FILL waits until the chain holds a
    // sampled value, LOAD captures it as baseline without reporting a step,
    // RUN tracks the pointer and reports every advance for one cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            bin_q   <= '0;
            step_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    step_q <= '0;
                    upd_q  <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    bin_q   <= bin_d;
                    step_q  <= '0;
                    upd_q   <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    bin_q  <= bin_d;
                    step_q <= diff_d;
                    upd_q  <= |diff_d;
                end
                default: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                    step_q  <= '0;
                    upd_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wq_rptr_bin  = bin_q;
    assign wq_rptr_step = step_q;
    assign wq_rptr_upd  = upd_q;

`ifdef PTR_SYNC_STEP_CHK_EN
    localparam logic [PTR_W-1:0] MAX_STEP_W = PTR_W'(MAX_STEP);

    logic step_big;
    logic step_err_q;

    // The check looks at the registered step, so the flag rises one edge
    // after the offending step is presented.
    assign step_big = (state_q == RUN) && (step_q > MAX_STEP_W);

    // Sticky error flag; a new violation takes priority over a clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            step_err_q <= 1'b0;
        end else if (step_big) begin
            step_err_q <= 1'b1;
        end else if (err_clr) begin
            step_err_q <= 1'b0;
        end
    end

    assign step_err = step_err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign step_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync_gray.sv
// tb_ptr_sync_gray: scoreboard bench for ptr_sync_gray. Stimulus is driven as
// binary values encoded to gray; each nonzero advance pushes the expected
// {due cycle, bin, step} onto a queue that a negedge monitor pops and checks.
// A second instance (PTR_W=6, SYNC_STAGES=3) covers the wider configuration.
`timescale 1ns/1ps
module tb_ptr_sync_gray;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int MAXS = 1;
`ifdef PTR_SYNC_STEP_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        int         due;
        logic [3:0] bin;
        logic [3:0] step;
    } sb_t;

    logic wclk;
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // DUT A: default configuration
    logic         wrst_n;
    logic [W-1:0] rptr;
    logic         err_clr;
    logic [W-1:0] wq2, bin, step;
    logic         upd, err;

    // DUT B: PTR_W=6, SYNC_STAGES=3
    logic         wrst_b_n;
    logic [5:0]   rptr_b;
    logic         err_clr_b;
    logic [5:0]   wq2_b, bin_b, step_b;
    logic         upd_b, err_b;

    ptr_sync_gray #(.PTR_W(W), .SYNC_STAGES(S), .MAX_STEP(MAXS)) u_dut (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .err_clr(err_clr),
        .wq2_rptr(wq2), .wq_rptr_bin(bin), .wq_rptr_step(step),
        .wq_rptr_upd(upd), .step_err(err)
    );

    ptr_sync_gray #(.PTR_W(6), .SYNC_STAGES(3), .MAX_STEP(MAXS)) u_dut_b (
        .wclk(wclk), .wrst_n(wrst_b_n), .rptr(rptr_b), .err_clr(err_clr_b),
        .wq2_rptr(wq2_b), .wq_rptr_bin(bin_b), .wq_rptr_step(step_b),
        .wq_rptr_upd(upd_b), .step_err(err_b)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic clr_s  = 1'b0;

    sb_t        sbq[$];
    sb_t        mon_e;
    logic [3:0] prev_b;
    logic [3:0] mbin;
    logic       exp_err;
    logic       pend;
    bit         mon_en;

    always @(posedge wclk) cyc <= cyc + 1;
    always @(posedge wclk) clr_s <= err_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] g6(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive a new binary pointer (as gray) and schedule the expected update.
    task automatic drive(input logic [3:0] b);
        logic [3:0] st;
        sb_t        e;
        st   = b - prev_b;
        rptr = g4(b);
        if (st != 4'd0) begin
            e.due  = cyc + 1 + S;
            e.bin  = b;
            e.step = st;
            sbq.push_back(e);
        end
        prev_b = b;
    endtask

    task automatic step_to(input logic [3:0] b, input int n);
        @(negedge wclk);
        drive(b);
        repeat (n - 1) @(negedge wclk);
    endtask

    task automatic prime_chk(input logic [3:0] g, input logic [3:0] b);
        @(negedge wclk);
        chk("prime1_wq2", wq2, 0);
        chk("prime1_bin", bin, 0);
        chk("prime1_upd", upd, 0);
        @(negedge wclk);
        chk("prime2_wq2", wq2, g);
        chk("prime2_bin", bin, 0);
        chk("prime2_upd", upd, 0);
        @(negedge wclk);
        chk("prime3_bin", bin, b);
        chk("prime3_upd", upd, 0);
        chk("prime3_step", step, 0);
        chk("prime3_err", err, 0);
    endtask

    // Scoreboard monitor: pops expected updates on their due cycle and checks
    // that nothing is reported in between.
    initial begin
        forever begin
            @(negedge wclk);
            if (mon_en) begin
                if (CHK_EN) exp_err = pend ? 1'b1 : (clr_s ? 1'b0 : exp_err);
                pend = 1'b0;
                if (sbq.size() != 0 && sbq[0].due == cyc) begin
                    mon_e = sbq.pop_front();
                    mbin  = mon_e.bin;
                    chk("upd", upd, 1);
                    chk("step", step, mon_e.step);
                    if (mon_e.step > MAXS) pend = 1'b1;
                end else begin
                    chk("upd_idle", upd, 0);
                    chk("step_idle", step, 0);
                end
                chk("bin", bin, mbin);
                chk("err", err, exp_err);
            end
        end
    end

    initial begin
        mon_en    = 1'b0;
        pend      = 1'b0;
        exp_err   = 1'b0;
        mbin      = 4'd0;
        err_clr   = 1'b0;
        err_clr_b = 1'b0;
        wrst_n    = 1'b1;
        wrst_b_n  = 1'b1;
        prev_b    = 4'd8;
        rptr      = g4(4'd8);
        rptr_b    = g6(6'd63);
        #1;
        wrst_n   = 1'b0;
        wrst_b_n = 1'b0;
        #2;
        chk("rst_wq2", wq2, 0);
        chk("rst_bin", bin, 0);
        chk("rst_step", step, 0);
        chk("rst_upd", upd, 0);
        chk("rst_err", err, 0);
        chk("rst_b_bin", bin_b, 0);
        @(negedge wclk);
        @(negedge wclk);
        wrst_n   = 1'b1;
        wrst_b_n = 1'b1;

        // Priming with a nonzero foreign pointer (gray C = bin 8)
        prime_chk(4'hC, 4'd8);
        mbin   = 4'd8;
        mon_en = 1'b1;

        // Unit walk 9..15, wrap to 0, then 1, 2
        for (int k = 9; k <= 18; k++) step_to(4'(k), 3);

        // Jump 2 -> 5 (step 3), then clear the flag with a lone pulse
        step_to(4'd5, 6);
        @(negedge wclk);
        err_clr = 1'b1;
        @(negedge wclk);
        err_clr = 1'b0;
        repeat (2) @(negedge wclk);
        step_to(4'd6, 3);
        step_to(4'd7, 6);

        // Reset mid-stream with bin = 7
        @(negedge wclk);
        mon_en = 1'b0;
        chk("pre_rst_bin", bin, 7);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_wq2", wq2, 0);
        chk("mid_rst_bin", bin, 0);
        chk("mid_rst_step", step, 0);
        chk("mid_rst_upd", upd, 0);
        chk("mid_rst_err", err, 0);
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        prime_chk(4'h4, 4'd7);
        sbq.delete();
        mbin    = 4'd7;
        exp_err = 1'b0;
        pend    = 1'b0;
        prev_b  = 4'd7;
        mon_en  = 1'b1;

        // Jump 7 -> 10 with err_clr on the very edge the flag is set
        @(negedge wclk);
        drive(4'd10);
        repeat (3) @(negedge wclk);
        err_clr = 1'b1;
        @(negedge wclk);
        err_clr = 1'b0;
        repeat (6) @(negedge wclk);
        chk("sb_drain", sbq.size(), 0);
        mon_en = 1'b0;

        // Wide instance: bin 63 -> 0 with three sync stages
        @(negedge wclk);
        chk("b_bin63", bin_b, 63);
        chk("b_wq2_63", wq2_b, 6'h20);
        rptr_b = g6(6'd0);
        @(negedge wclk);
        chk("b_e1_wq2", wq2_b, 6'h20);
        @(negedge wclk);
        chk("b_e2_wq2", wq2_b, 6'h20);
        @(negedge wclk);
        chk("b_e3_wq2", wq2_b, 0);
        chk("b_e3_bin", bin_b, 63);
        chk("b_e3_upd", upd_b, 0);
        @(negedge wclk);
        chk("b_e4_bin", bin_b, 0);
        chk("b_e4_step", step_b, 1);
        chk("b_e4_upd", upd_b, 1);
        @(negedge wclk);
        chk("b_e5_upd", upd_b, 0);
        chk("b_e5_step", step_b, 0);
        chk("b_err", err_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
